// File: rtl/alu_unit_pkg.sv
// Shared constants for the integer execute stage: opcode map,
// field widths, divider FSM states and iteration count.
package alu_unit_pkg;

   localparam int CALC_OP_L1_NUM_WIDTH = 4;
   localparam int ROB_SIZE_WIDTH       = 4;
   localparam int DIV_CYCLES           = 32;

   // Primary opcode map; L2 selects the variant noted alongside.
   typedef enum logic [CALC_OP_L1_NUM_WIDTH-1:0] {
      OP_ADD  = 4'd0,   // ADD / SUB
      OP_SLL  = 4'd1,
      OP_SLT  = 4'd2,
      OP_SLTU = 4'd3,
      OP_XOR  = 4'd4,
      OP_SR   = 4'd5,   // SRL / SRA
      OP_OR   = 4'd6,
      OP_AND  = 4'd7,
      OP_EQ   = 4'd8,   // EQ / NE
      OP_LT   = 4'd9,   // LT / GE
      OP_LTU  = 4'd10,  // LTU / GEU
      OP_MUL  = 4'd11,  // MUL / MULHU
      OP_DIV  = 4'd12,  // DIV / REM
      OP_DIVU = 4'd13   // DIVU / REMU
   } op_l1_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIV_RUN  = 2'd1,
      ST_DIV_DONE = 2'd2
   } alu_state_e;

   // Compare ops produce a 0/1 word.
   function automatic logic [31:0] flag32(input logic f);
      return {31'd0, f};
   endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider (unsigned magnitudes) used by alu_unit for
// DIV/DIVU/REM/REMU. Only built when ALU_MULDIV_EN is defined.
//   clk_i, rst_n_i      clock, async active-low reset
//   en_i                global enable; low freezes all state
//   start_i             load dividend_i / divisor_i and begin
//   abort_i             drop the operation in flight
//   done_o              this edge performs the final iteration
//   quot_o, rem_o       quotient / remainder after this edge's iteration
`ifdef ALU_MULDIV_EN
module alu_divider
   import alu_unit_pkg::*;
#(
   parameter int ITERS = DIV_CYCLES
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        done_o,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o
);

   localparam int CW = $clog2(ITERS + 1);

   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   q_q, r_q, d_q;
   logic [31:0]   q_d, r_d, sh;
   logic          ge;

   // Shift the next dividend bit into the partial remainder. r_q[31]
   // acts as the 33rd bit: if set, the shifted value exceeds any divisor
   // and the 32-bit wrapped subtraction is still exact.
   always_comb begin
      sh  = {r_q[30:0], q_q[31]};
      ge  = r_q[31] | (sh >= d_q);
      r_d = ge ? (sh - d_q) : sh;
      q_d = {q_q[30:0], ge};
   end

   assign done_o = busy_q && (cnt_q == CW'(1));
   assign quot_o = q_d;
   assign rem_o  = r_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         q_q    <= '0;
         r_q    <= '0;
         d_q    <= '0;
      end else if (en_i) begin
         if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(ITERS);
            q_q    <= dividend_i;
            r_q    <= '0;
            d_q    <= divisor_i;
         end else if (busy_q) begin
            q_q   <= q_d;
            r_q   <= r_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
         end
      end
   end

endmodule
`endif

// File: rtl/alu_unit.sv
// Integer execute stage: one issued op per cycle, registered result bus
// (alu_valid/alu_value/alu_dependency) back to RS wakeup and ROB.
//   clk_in, rst_n_in     clock, async active-low reset
//   rdy_in               global enable; low freezes all state
//   need_flush_in        mispredict flush (drops result and divide)
//   rs2alu_*             issue valid, op L1/L2, operands, ROB id
//   alu_valid/value/dependency   result broadcast
//   alu_ready_out        can accept an issue this cycle
// Optional: define ALU_MULDIV_EN for MUL/MULHU and iterative DIV/REM.
module alu_unit
   import alu_unit_pkg::*;
(
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            rdy_in,
   input  logic                            need_flush_in,
   input  logic                            rs2alu_ready,
   input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
   input  logic                            rs2alu_op_L2,
   input  logic [31:0]                     rs2alu_opr1,
   input  logic [31:0]                     rs2alu_opr2,
   input  logic [ROB_SIZE_WIDTH-1:0]       rs2alu_dependency,
   output logic                            alu_valid,
   output logic [31:0]                     alu_value,
   output logic [ROB_SIZE_WIDTH-1:0]       alu_dependency,
   output logic                            alu_ready_out
);

   logic [31:0] a, b;
   logic [4:0]  sh;
   logic        l2;
   logic [31:0] res_d;

   logic                      valid_q;
   logic [31:0]               value_q;
   logic [ROB_SIZE_WIDTH-1:0] dep_q;

   assign a  = rs2alu_opr1;
   assign b  = rs2alu_opr2;
   assign sh = rs2alu_opr2[4:0];
   assign l2 = rs2alu_op_L2;

`ifdef ALU_MULDIV_EN
   logic [63:0] prod;
   logic        is_div, sgn, a_neg, b_neg;
   logic        div0, ovf, div_long, div_start;
   logic [31:0] a_mag, b_mag;
   logic        div_done;
   logic [31:0] div_q, div_r, q_fin, r_fin;

   alu_state_e                state_q;
   logic                      ready_q;
   logic                      rem_sel_q;
   logic                      neg_q_q;
   logic                      neg_r_q;
   logic [ROB_SIZE_WIDTH-1:0] div_dep_q;

   assign prod   = {32'd0, a} * {32'd0, b};
   assign is_div = (rs2alu_op_L1 == OP_DIV) || (rs2alu_op_L1 == OP_DIVU);
   assign sgn    = (rs2alu_op_L1 == OP_DIV);
   assign a_neg  = sgn & a[31];
   assign b_neg  = sgn & b[31];
   assign a_mag  = a_neg ? (32'd0 - a) : a;
   assign b_mag  = b_neg ? (32'd0 - b) : b;
   assign div0   = (b == 32'd0);
   assign ovf    = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // Zero divisor and signed overflow are answered in the single-cycle
   // path; only the remaining divides occupy the iterative unit.
   assign div_long  = is_div && !div0 && !ovf;
   assign div_start = rdy_in && !need_flush_in && rs2alu_ready &&
                      ready_q && div_long;

   alu_divider #(
      .ITERS (DIV_CYCLES)
   ) u_div (
      .clk_i      (clk_in),
      .rst_n_i    (rst_n_in),
      .en_i       (rdy_in),
      .start_i    (div_start),
      .abort_i    (need_flush_in),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .done_o     (div_done),
      .quot_o     (div_q),
      .rem_o      (div_r)
   );

   assign q_fin = neg_q_q ? (32'd0 - div_q) : div_q;
   assign r_fin = neg_r_q ? (32'd0 - div_r) : div_r;
`endif

   always_comb begin
      res_d = '0;
      unique case (rs2alu_op_L1)
         OP_ADD:  res_d = l2 ? (a - b) : (a + b);
         OP_SLL:  res_d = a << sh;
         OP_SLT:  res_d = flag32($signed(a) < $signed(b));
         OP_SLTU: res_d = flag32(a < b);
         OP_XOR:  res_d = a ^ b;
         OP_SR:   res_d = l2 ? $unsigned($signed(a) >>> sh) : (a >> sh);
         OP_OR:   res_d = a | b;
         OP_AND:  res_d = a & b;
         OP_EQ:   res_d = flag32(l2 ^ (a == b));
         OP_LT:   res_d = flag32(l2 ^ ($signed(a) < $signed(b)));
         OP_LTU:  res_d = flag32(l2 ^ (a < b));
`ifdef ALU_MULDIV_EN
         OP_MUL:  res_d = l2 ? prod[63:32] : prod[31:0];
         OP_DIV, OP_DIVU: begin
            if (div0)     res_d = l2 ? a : 32'hFFFF_FFFF;
            else if (ovf) res_d = l2 ? 32'd0 : 32'h8000_0000;
         end
`endif
         default: res_d = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         value_q   <= '0;
         dep_q     <= '0;
         rem_sel_q <= 1'b0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         div_dep_q <= '0;
      end else if (rdy_in) begin
         if (need_flush_in) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_DIV_RUN: begin
                  valid_q <= 1'b0;
                  // Final iteration lands this edge: publish directly.
                  if (div_done) begin
                     state_q <= ST_DIV_DONE;
                     ready_q <= 1'b1;
                     valid_q <= 1'b1;
                     value_q <= rem_sel_q ? r_fin : q_fin;
                     dep_q   <= div_dep_q;
                  end
               end
               default: begin
                  // IDLE and DIV_DONE both accept a new issue.
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  if (rs2alu_ready) begin
                     if (div_long) begin
                        state_q   <= ST_DIV_RUN;
                        ready_q   <= 1'b0;
                        rem_sel_q <= l2;
                        neg_q_q   <= a_neg ^ b_neg;
                        neg_r_q   <= a_neg;
                        div_dep_q <= rs2alu_dependency;
                     end else begin
                        valid_q <= 1'b1;
                        value_q <= res_d;
                        dep_q   <= rs2alu_dependency;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign alu_ready_out = ready_q;
`else
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;
         value_q <= '0;
         dep_q   <= '0;
      end else if (rdy_in) begin
         if (need_flush_in) begin
            valid_q <= 1'b0;
         end else if (rs2alu_ready) begin
            valid_q <= 1'b1;
            value_q <= res_d;
            dep_q   <= rs2alu_dependency;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign alu_ready_out = 1'b1;
`endif

   assign alu_valid      = valid_q;
   assign alu_value      = value_q;
   assign alu_dependency = dep_q;

`ifndef SYNTHESIS
   // Issuing while busy is an RS protocol violation; the op is dropped.
   a_issue_when_ready: assert property (
      @(posedge clk_in) disable iff (!rst_n_in)
      (rdy_in && rs2alu_ready) |-> alu_ready_out
   );
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed, table-driven bench for alu_unit (both with and without
// ALU_MULDIV_EN).
module tb_alu_unit;
   import alu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, rdy, flush, iss;
   logic [3:0]  op;
   logic        l2;
   logic [31:0] a, b;
   logic [3:0]  id;
   logic        valid;
   logic [31:0] value;
   logic [3:0]  dep;
   logic        ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_unit dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .rdy_in            (rdy),
      .need_flush_in     (flush),
      .rs2alu_ready      (iss),
      .rs2alu_op_L1      (op),
      .rs2alu_op_L2      (l2),
      .rs2alu_opr1       (a),
      .rs2alu_opr2       (b),
      .rs2alu_dependency (id),
      .alu_valid         (valid),
      .alu_value         (value),
      .alu_dependency    (dep),
      .alu_ready_out     (ready)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic        l2;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  id;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic v,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t);
      iss = 1'b1; op = o; l2 = v; a = x; b = y; id = t;
   endtask

   task automatic idle();
      iss = 1'b0;
   endtask

`ifdef ALU_MULDIV_EN
   // Issue a divide, optionally freeze 5 cycles at offset fz, and check
   // the latency (edges after acceptance) and cycles with ready low.
   task automatic run_div(input string nm, input logic [3:0] o,
                          input logic v, input logic [31:0] x,
                          input logic [31:0] y, input logic [3:0] t,
                          input logic [31:0] exp, input int expk,
                          input int fz);
      int k;
      int low;
      issue(o, v, x, y, t);
      step();
      idle();
      k = 0;
      low = 0;
      while (k < 80) begin
         if (valid) break;
         if (!ready) low++;
         if (k == fz) rdy = 1'b0;
         if (k == fz + 5) rdy = 1'b1;
         step();
         k++;
      end
      rdy = 1'b1;
      chk({nm, " latency"}, k, expk);
      chk({nm, " ready_low"}, low, expk);
      chk({nm, " value"}, value, exp);
      chk({nm, " id"}, {28'd0, dep}, {28'd0, t});
      chk({nm, " ready_at_valid"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic count_valid(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (valid) c++;
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; iss = 1'b0;
      op = '0; l2 = 1'b0; a = '0; b = '0; id = '0;

      vecs.push_back('{OP_ADD,  1'b1, 32'd5,        32'd7,        4'd1, 32'hFFFF_FFFE});
      vecs.push_back('{OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'd1,       4'd2, 32'h0});
      vecs.push_back('{OP_SLL,  1'b0, 32'd1,        32'h3F,       4'd3, 32'h8000_0000});
      vecs.push_back('{OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1,       4'd4, 32'd1});
      vecs.push_back('{OP_SLTU, 1'b0, 32'd1,        32'hFFFF_FFFF, 4'd5, 32'd1});
      vecs.push_back('{OP_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 32'h0FF0_0FF0});
      vecs.push_back('{OP_SR,   1'b0, 32'h8000_0000, 32'd4,       4'd7, 32'h0800_0000});
      vecs.push_back('{OP_SR,   1'b1, 32'h8000_0000, 32'd4,       4'd8, 32'hF800_0000});
      vecs.push_back('{OP_OR,   1'b0, 32'h1234_0000, 32'h0000_5678, 4'd9, 32'h1234_5678});
      vecs.push_back('{OP_AND,  1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd10, 32'h0F0F_0000});
      vecs.push_back('{OP_EQ,   1'b0, 32'd5,        32'd5,        4'd11, 32'd1});
      vecs.push_back('{OP_EQ,   1'b1, 32'd5,        32'd5,        4'd12, 32'd0});
      vecs.push_back('{OP_LT,   1'b0, 32'hFFFF_FFFF, 32'd0,       4'd13, 32'd1});
      vecs.push_back('{OP_LT,   1'b1, 32'hFFFF_FFFF, 32'd0,       4'd14, 32'd0});
      vecs.push_back('{OP_LTU,  1'b0, 32'd0,        32'd1,        4'd15, 32'd1});
      vecs.push_back('{OP_LTU,  1'b1, 32'd0,        32'd1,        4'd0, 32'd0});
      vecs.push_back('{4'd14,   1'b0, 32'd3,        32'd4,        4'd1, 32'd0});
      vecs.push_back('{4'd15,   1'b1, 32'd3,        32'd4,        4'd2, 32'd0});
`ifdef ALU_MULDIV_EN
      vecs.push_back('{OP_MUL,  1'b0, 32'h0001_0000, 32'h0001_0000, 4'd3, 32'd0});
      vecs.push_back('{OP_MUL,  1'b1, 32'h0001_0000, 32'h0001_0000, 4'd4, 32'd1});
      vecs.push_back('{OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'd1});
      vecs.push_back('{OP_MUL,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'hFFFF_FFFE});
`else
      vecs.push_back('{OP_MUL,  1'b0, 32'd3,        32'd4,        4'd3, 32'd0});
      vecs.push_back('{OP_DIV,  1'b0, 32'd8,        32'd2,        4'd4, 32'd0});
      vecs.push_back('{OP_DIVU, 1'b0, 32'd8,        32'd2,        4'd5, 32'd0});
`endif

      // Reset state
      repeat (3) step();
      chk("rst valid", {31'd0, valid}, 32'd0);
      chk("rst value", value, 32'd0);
      chk("rst id", {28'd0, dep}, 32'd0);
      chk("rst ready", {31'd0, ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // ADD 5+7 id 3: one-cycle pulse, then hold
      issue(OP_ADD, 1'b0, 32'd5, 32'd7, 4'd3);
      step();
      idle();
      chk("add valid", {31'd0, valid}, 32'd1);
      chk("add value", value, 32'd12);
      chk("add id", {28'd0, dep}, 32'd3);
      step();
      chk("add pulse_end", {31'd0, valid}, 32'd0);
      chk("add hold", value, 32'd12);

      // Table, issued back-to-back
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].op, vecs[i].l2, vecs[i].a, vecs[i].b, vecs[i].id);
         step();
         chk($sformatf("vec%0d valid", i), {31'd0, valid}, 32'd1);
         chk($sformatf("vec%0d value", i), value, vecs[i].exp);
         chk($sformatf("vec%0d id", i), {28'd0, dep}, {28'd0, vecs[i].id});
      end
      idle();
      step();
      chk("tbl idle", {31'd0, valid}, 32'd0);

      // XOR, OR, AND ids 1,2,3 back-to-back
      issue(OP_XOR, 1'b0, 32'hA, 32'h3, 4'd1);
      step();
      chk("b2b xor", {valid, 23'd0, dep, value[3:0]}, {1'b1, 23'd0, 4'd1, 4'h9});
      issue(OP_OR, 1'b0, 32'hA, 32'h3, 4'd2);
      step();
      chk("b2b or", {valid, 23'd0, dep, value[3:0]}, {1'b1, 23'd0, 4'd2, 4'hB});
      issue(OP_AND, 1'b0, 32'hA, 32'h3, 4'd3);
      step();
      chk("b2b and", {valid, 23'd0, dep, value[3:0]}, {1'b1, 23'd0, 4'd3, 4'h2});
      idle();
      step();

      // Flush in the same cycle as an issue
      issue(OP_ADD, 1'b0, 32'd1, 32'd2, 4'd6);
      flush = 1'b1;
      step();
      idle();
      flush = 1'b0;
      chk("flush valid", {31'd0, valid}, 32'd0);
      chk("flush ready", {31'd0, ready}, 32'd1);
      chk("flush id_held", {28'd0, dep}, 32'd3);
      step();
      chk("flush late", {31'd0, valid}, 32'd0);

      // Freeze with a result showing and an issue pending
      issue(OP_ADD, 1'b0, 32'd1, 32'd1, 4'd9);
      step();
      rdy = 1'b0;
      issue(OP_ADD, 1'b0, 32'd3, 32'd3, 4'd10);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("frz%0d", i), {valid, 23'd0, dep, value[3:0]},
             {1'b1, 23'd0, 4'd9, 4'd2});
      end
      idle();
      rdy = 1'b1;
      step();
      chk("frz end", {valid, 23'd0, dep, value[3:0]},
          {1'b0, 23'd0, 4'd9, 4'd2});

      // Asynchronous reset mid-cycle with a result on the bus
      issue(OP_ADD, 1'b0, 32'd4, 32'd4, 4'd11);
      step();
      idle();
      chk("pre_rst value", value, 32'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("arst valid", {31'd0, valid}, 32'd0);
      chk("arst value", value, 32'd0);
      chk("arst id", {28'd0, dep}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

`ifdef ALU_MULDIV_EN
      begin
         int c;
         run_div("div", OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 4'd4,
                 32'hFFFF_FFFD, DIV_CYCLES, -1);
         // Issue accepted in the cycle the divide result pulses
         issue(OP_ADD, 1'b0, 32'd2, 32'd3, 4'd5);
         step();
         idle();
         chk("post_div add", {valid, 23'd0, dep, value[3:0]},
             {1'b1, 23'd0, 4'd5, 4'd5});
         run_div("rem", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'd6,
                 32'hFFFF_FFFF, DIV_CYCLES, -1);
         run_div("divu", OP_DIVU, 1'b0, 32'd100, 32'd7, 4'd7,
                 32'd14, DIV_CYCLES, -1);
         run_div("remu", OP_DIVU, 1'b1, 32'd100, 32'd7, 4'd8,
                 32'd2, DIV_CYCLES, -1);
         run_div("div0", OP_DIV, 1'b0, 32'd5, 32'd0, 4'd9,
                 32'hFFFF_FFFF, 0, -1);
         run_div("rem0", OP_DIVU, 1'b1, 32'd5, 32'd0, 4'd10,
                 32'd5, 0, -1);
         run_div("ovf", OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                 4'd11, 32'h8000_0000, 0, -1);
         run_div("ovfrem", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                 4'd12, 32'd0, 0, -1);
         run_div("frzdiv", OP_DIVU, 1'b0, 32'd100, 32'd7, 4'd13,
                 32'd14, DIV_CYCLES + 5, 10);
         idle();
         step();

         // Flush mid divide
         issue(OP_DIVU, 1'b0, 32'd100, 32'd7, 4'd14);
         step();
         idle();
         repeat (5) step();
         flush = 1'b1;
         step();
         flush = 1'b0;
         chk("dflush valid", {31'd0, valid}, 32'd0);
         chk("dflush ready", {31'd0, ready}, 32'd1);
         count_valid(40, c);
         chk("dflush no_result", c, 32'd0);

         // Reset mid divide
         issue(OP_DIVU, 1'b0, 32'd100, 32'd7, 4'd15);
         step();
         idle();
         repeat (10) step();
         chk("drst busy", {31'd0, ready}, 32'd0);
         #2 rst_n = 1'b0;
         #1;
         chk("drst valid", {31'd0, valid}, 32'd0);
         chk("drst value", value, 32'd0);
         chk("drst ready", {31'd0, ready}, 32'd1);
         step();
         rst_n = 1'b1;
         count_valid(40, c);
         chk("drst no_result", c, 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
